// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: parallel load/clear, single-step shift/rotate,
// and counted burst mode with busy/done handshake.
module univ_shift_reg #(
  parameter int unsigned           WIDTH     = 8,
  parameter int unsigned           AMT_W     = 4,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [AMT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       op_r, op_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       f_op,
    input logic [WIDTH-1:0] f_q,
    input logic [WIDTH-1:0] f_d,
    input logic             f_sin_l,
    input logic             f_sin_r
  );
    logic [WIDTH-1:0] r;
    case (f_op)
      3'b000:  r = f_q;
      3'b001:  r = f_d;
      3'b010:  r = {f_q[WIDTH-2:0], f_sin_r};
      3'b011:  r = {f_sin_l, f_q[WIDTH-1:1]};
      3'b100:  r = {f_q[WIDTH-2:0], f_q[WIDTH-1]};
      3'b101:  r = {f_q[0], f_q[WIDTH-1:1]};
      3'b110:  r = {f_q[WIDTH-1], f_q[WIDTH-1:1]};
      3'b111:  r = {WIDTH{1'b0}};
      default: r = f_q;
    endcase
    return r;
  endfunction

  // Only the pure shift/rotate ops may be run as a burst.
  function automatic logic is_burst_op(input logic [2:0] f_op);
    return (f_op >= 3'b010) && (f_op <= 3'b110);
  endfunction

  // Next-state and next-output logic for the IDLE/RUN controller.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    op_s    = op_r;
    q_s     = q_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          // start with a non-burst op swallows the cycle; en is not looked at
          if (is_burst_op(op)) begin
            if (amt != {AMT_W{1'b0}}) begin
              op_s    = op;
              cnt_s   = amt;
              busy_s  = 1'b1;
              state_s = RUN;
            end else begin
              done_s = 1'b1;
            end
          end else begin
            q_s = q_r;
          end
        end else if (en) begin
          q_s = apply_op(op, q_r, d, sin_l, sin_r);
        end else begin
          q_s = q_r;
        end
      end
      RUN: begin
        q_s   = apply_op(op_r, q_r, d, sin_l, sin_r);
        cnt_s = cnt_r - AMT_W'(1);
        if (cnt_r == AMT_W'(1)) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {AMT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {AMT_W{1'b0}};
      op_r    <= 3'b000;
      q_r     <= RESET_VAL;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
      q_r     <= q_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign q      = q_r;
  assign q_n    = ~q_r;
  assign sout_l = q_r[WIDTH-1];
  assign sout_r = q_r[0];
  assign busy   = busy_r;
  assign done   = done_r;

endmodule
